// File: rtl/dmem_responder.sv
// Single-outstanding RV64 data memory responder: fixed-latency valid/ready load/store with lane steering.
// Build option DMEM_MISALIGN_TRAP_EN: misaligned accesses report rsp_err instead of being force-aligned.
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  count, count_next;
  logic        accept, access;

  logic        buf_we;
  logic [63:0] buf_addr, buf_wdata;
  logic [2:0]  buf_funct3;

  logic        acc_we;
  logic [63:0] acc_addr, acc_wdata;
  logic [2:0]  acc_funct3;

  logic [2:0]      low_mask;
  logic            misaligned, acc_err;
  logic [63:0]     eff_addr;
  logic [IDXW-1:0] word_idx;
  logic [5:0]      shift;
  logic [63:0]     word_raw, lane_data, load_data, write_data;
  logic [7:0]      byte_base, byte_en;

  logic [63:0] mem [DEPTH];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;

  // With LATENCY==1 the access edge is the acceptance edge, so the live request is used directly.
  assign acc_we     = (state == IDLE) ? req_we     : buf_we;
  assign acc_addr   = (state == IDLE) ? req_addr   : buf_addr;
  assign acc_wdata  = (state == IDLE) ? req_wdata  : buf_wdata;
  assign acc_funct3 = (state == IDLE) ? req_funct3 : buf_funct3;

  always_comb begin
    state_next = state;
    count_next = count;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
            access     = 1'b1;
          end else begin
            state_next = WAIT;
            count_next = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        count_next = count - 4'd1;
        if (count == 4'd1) begin
          state_next = RESP;
          access     = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    low_mask  = 3'b000;
    byte_base = 8'h01;
    case (acc_funct3[1:0])
      2'b00: begin low_mask = 3'b000; byte_base = 8'h01; end
      2'b01: begin low_mask = 3'b001; byte_base = 8'h03; end
      2'b10: begin low_mask = 3'b011; byte_base = 8'h0F; end
      default: begin low_mask = 3'b111; byte_base = 8'hFF; end
    endcase
    misaligned = |(acc_addr[2:0] & low_mask);
`ifdef DMEM_MISALIGN_TRAP_EN
    eff_addr = acc_addr;
    acc_err  = misaligned;
`else
    eff_addr = {acc_addr[63:3], acc_addr[2:0] & ~low_mask};
    acc_err  = 1'b0;
`endif
    if (acc_funct3 == 3'b111) acc_err = 1'b1;
    if (eff_addr >= 64'(DEPTH) * 64'd8) acc_err = 1'b1;

    word_idx   = eff_addr[IDXW+2:3];
    shift      = {eff_addr[2:0], 3'b000};
    word_raw   = mem[word_idx];
    lane_data  = word_raw >> shift;
    write_data = acc_wdata << shift;
    byte_en    = byte_base << eff_addr[2:0];

    load_data = 64'd0;
    case (acc_funct3)
      3'b000:  load_data = {{56{lane_data[7]}},  lane_data[7:0]};
      3'b001:  load_data = {{48{lane_data[15]}}, lane_data[15:0]};
      3'b010:  load_data = {{32{lane_data[31]}}, lane_data[31:0]};
      3'b011:  load_data = lane_data;
      3'b100:  load_data = {56'd0, lane_data[7:0]};
      3'b101:  load_data = {48'd0, lane_data[15:0]};
      3'b110:  load_data = {32'd0, lane_data[31:0]};
      default: load_data = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_we     <= req_we;
      buf_addr   <= req_addr;
      buf_wdata  <= req_wdata;
      buf_funct3 <= req_funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= 64'd0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || acc_we) ? 64'd0 : load_data;
    end
  end

  // The array is deliberately outside reset; a reset only suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!reset && access && acc_we && !acc_err) begin
      for (int k = 0; k < 8; k++) begin
        if (byte_en[k]) mem[word_idx][8*k +: 8] <= write_data[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LATENCY 2, 4, 1) against a byte-array model.
// Honours DMEM_MISALIGN_TRAP_EN the same way the design does.
module tb_dmem_responder;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_we     [NI];
  logic [63:0] req_addr   [NI];
  logic [63:0] req_wdata  [NI];
  logic [2:0]  req_funct3 [NI];
  logic        rsp_valid  [NI];
  logic        rsp_ready  [NI];
  logic [63:0] rsp_rdata  [NI];
  logic        rsp_err    [NI];

  logic [7:0] mdl [NI][1024];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(.DEPTH(128), .LATENCY(g == 0 ? 2 : (g == 1 ? 4 : 1))) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_funct3(req_funct3[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 4 : 1);
  endfunction

  // Reference: byte-addressed memory, size from funct3, alignment by modulo arithmetic.
  task automatic model(input int i, input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [2:0] f3, output logic [63:0] rd, output logic e);
    longint unsigned size, a;
    rd = '0;
    e = 1'b0;
    size = 64'd1 << f3[1:0];
    a = addr;
    if (f3 == 3'b111) begin e = 1'b1; return; end
    if (a % size != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      e = 1'b1;
      return;
`else
      a = a - (a % size);
`endif
    end
    if (a >= 1024) begin e = 1'b1; return; end
    for (int k = 0; k < int'(size); k++) begin
      if (we) mdl[i][int'(a) + k] = wdata[8*k +: 8];
      else    rd[8*k +: 8] = mdl[i][int'(a) + k];
    end
    if (!we && !f3[2] && size < 8 && rd[8*size-1])
      for (int k = int'(size); k < 8; k++) rd[8*k +: 8] = 8'hFF;
  endtask

  task automatic do_txn(input int i, input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [2:0] f3, input int hold,
                        output logic [63:0] rd, output logic e, output int lat,
                        output logic stable, output logic ready_after, output logic ok);
    int n;
    rd = '0; e = 1'b0; lat = 0; stable = 1'b1; ready_after = 1'b0; ok = 1'b1;
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = addr;
    req_wdata[i] = wdata; req_funct3[i] = f3;
    rsp_ready[i] = (hold == 0);
    n = 0;
    while (req_ready[i] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin ok = 1'b0; req_valid[i] = 1'b0; return; end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    req_we[i] = 1'($urandom); req_addr[i] = {$urandom, $urandom};
    req_wdata[i] = {$urandom, $urandom}; req_funct3[i] = 3'($urandom);
    lat = 1;
    while (rsp_valid[i] !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    if (rsp_valid[i] !== 1'b1) begin ok = 1'b0; return; end
    rd = rsp_rdata[i];
    e = rsp_err[i];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (rsp_valid[i] !== 1'b1 || rsp_rdata[i] !== rd || rsp_err[i] !== e || req_ready[i] !== 1'b0)
        stable = 1'b0;
    end
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
    ready_after = (req_ready[i] === 1'b1) && (rsp_valid[i] === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rsp_valid[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid[%0d]: got %b want 0", i, rsp_valid[i]); end
      checks++;
      if (req_ready[i] !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready[%0d]: got %b want 1", i, req_ready[i]); end
      checks++;
      if (rsp_rdata[i] !== 64'd0) begin errors++; $display("[TB] FAIL reset_rdata[%0d]: got %h want 0", i, rsp_rdata[i]); end
      checks++;
      if (rsp_err[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_err[%0d]: got %b want 0", i, rsp_err[i]); end
    end
  endtask

  task automatic test_prefill();
    logic [63:0] rd, exp_rd, wd;
    logic e, exp_e, st, ra, ok;
    int lat;
    for (int i = 0; i < NI; i++) begin
      for (int w = 0; w < 16; w++) begin
        wd = {$urandom, $urandom};
        model(i, 1'b1, 64'(w * 8), wd, 3'b011, exp_rd, exp_e);
        do_txn(i, 1'b1, 64'(w * 8), wd, 3'b011, 0, rd, e, lat, st, ra, ok);
        checks++;
        if (!ok || lat != lat_of(i) || rd !== exp_rd || e !== exp_e || !ra) begin
          errors++;
          $display("[TB] FAIL prefill[%0d] w%0d: got rd=%h err=%b lat=%0d ok=%b rdy=%b want rd=%h err=%b lat=%0d",
                   i, w, rd, e, lat, ok, ra, exp_rd, exp_e, lat_of(i));
        end
      end
    end
  endtask

  task automatic test_lanes();
    logic        v_we  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0]  v_f3  [8] = '{3'b011, 3'b011, 3'b000, 3'b000, 3'b100, 3'b011, 3'b001, 3'b110};
    logic [63:0] v_ad  [8] = '{64'h10, 64'h10, 64'h13, 64'h13, 64'h13, 64'h10, 64'h12, 64'h14};
    logic [63:0] v_wd  [8] = '{64'h1122334455667788, 64'h0, 64'h80, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    logic [63:0] v_exp [8] = '{64'h0, 64'h1122334455667788, 64'h0, 64'hFFFFFFFFFFFFFF80,
                               64'h80, 64'h1122334480667788, 64'hFFFFFFFFFFFF8066, 64'h11223344};
    logic [63:0] rd, m_rd;
    logic e, m_e, st, ra, ok;
    int lat;
    for (int v = 0; v < 8; v++) begin
      model(0, v_we[v], v_ad[v], v_wd[v], v_f3[v], m_rd, m_e);
      do_txn(0, v_we[v], v_ad[v], v_wd[v], v_f3[v], 0, rd, e, lat, st, ra, ok);
      checks++;
      if (!ok || lat != 2 || rd !== v_exp[v] || e !== 1'b0) begin
        errors++;
        $display("[TB] FAIL lanes[%0d]: got rd=%h err=%b lat=%0d ok=%b want rd=%h err=0 lat=2",
                 v, rd, e, lat, ok, v_exp[v]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd;
    logic e, st, ra, ok;
    int lat;
    do_txn(0, 1'b0, 64'h10, 64'h0, 3'b011, 5, rd, e, lat, st, ra, ok);
    checks++;
    if (!ok || lat != 2 || rd !== 64'h1122334480667788 || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_data: got rd=%h err=%b lat=%0d want rd=1122334480667788 err=0 lat=2", rd, e, lat);
    end
    checks++;
    if (st !== 1'b1) begin errors++; $display("[TB] FAIL backpressure_stable: got %b want 1", st); end
    checks++;
    if (ra !== 1'b1) begin errors++; $display("[TB] FAIL backpressure_ready_after: got %b want 1", ra); end
  endtask

  task automatic test_errors();
    logic        v_we [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  v_f3 [6] = '{3'b010, 3'b111, 3'b011, 3'b011, 3'b001, 3'b011};
    logic [63:0] v_ad [6] = '{64'h402, 64'h8, 64'h8000000000000010, 64'h400, 64'h21, 64'h20};
    logic [63:0] rd, exp_rd;
    logic e, exp_e, st, ra, ok;
    int lat;
    for (int v = 0; v < 6; v++) begin
      model(0, v_we[v], v_ad[v], 64'h5A5AABCD, v_f3[v], exp_rd, exp_e);
      if (v < 4) exp_e = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (v == 4) exp_e = 1'b1;
`else
      if (v == 4) exp_e = 1'b0;
`endif
      do_txn(0, v_we[v], v_ad[v], 64'h5A5AABCD, v_f3[v], 0, rd, e, lat, st, ra, ok);
      checks++;
      if (!ok || lat != 2 || rd !== exp_rd || e !== exp_e) begin
        errors++;
        $display("[TB] FAIL errors[%0d]: got rd=%h err=%b lat=%0d ok=%b want rd=%h err=%b lat=2",
                 v, rd, e, lat, ok, exp_rd, exp_e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd, exp_rd;
    logic e, exp_e, st, ra, ok;
    int lat, n;
    model(1, 1'b0, 64'h30, 64'h0, 3'b011, exp_rd, exp_e);
    do_txn(1, 1'b0, 64'h30, 64'h0, 3'b011, 0, rd, e, lat, st, ra, ok);
    checks++;
    if (!ok || lat != 4 || rd !== exp_rd) begin
      errors++; $display("[TB] FAIL reset_mid_preload: got rd=%h lat=%0d want rd=%h lat=4", rd, lat, exp_rd);
    end
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 64'h30;
    req_wdata[1] = 64'hDEADBEEF00000000; req_funct3[1] = 3'b011;
    n = 0;
    while (req_ready[1] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rsp_valid[i] !== 1'b0 || req_ready[i] !== 1'b1 || rsp_rdata[i] !== 64'd0 || rsp_err[i] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_mid_outputs[%0d]: got valid=%b ready=%b rdata=%h err=%b want 0 1 0 0",
                 i, rsp_valid[i], req_ready[i], rsp_rdata[i], rsp_err[i]);
      end
    end
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rsp_valid[1] !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("[TB] FAIL reset_mid_abort: got %0d valid cycles want 0", n); end
    do_txn(1, 1'b0, 64'h30, 64'h0, 3'b011, 0, rd, e, lat, st, ra, ok);
    checks++;
    if (!ok || lat != 4 || rd !== exp_rd || e !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid_contents: got rd=%h err=%b lat=%0d want rd=%h err=0 lat=4", rd, e, lat, exp_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_rd;
    logic exp_e;
    int acc, rsps, bad;
    model(2, 1'b0, 64'h8, 64'h0, 3'b011, exp_rd, exp_e);
    acc = 0; rsps = 0; bad = 0;
    rsp_ready[2] = 1'b1;
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 64'h8; req_funct3[2] = 3'b011;
    for (int c = 0; c < 12; c++) begin
      if (req_ready[2] === 1'b1) acc++;
      if (rsp_valid[2] === 1'b1) begin
        rsps++;
        if (rsp_rdata[2] !== exp_rd || rsp_err[2] !== 1'b0) bad++;
      end
      @(posedge clk); #1;
    end
    req_valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rsp_ready[2] = 1'b0;
    checks++;
    if (acc != 6 || rsps != 6) begin
      errors++; $display("[TB] FAIL back_to_back_rate: got accepts=%0d responses=%0d want 6 6", acc, rsps);
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL back_to_back_data: got %0d bad responses want 0", bad); end
  endtask

  task automatic test_random();
    logic [63:0] rd, exp_rd, ad, wd;
    logic e, exp_e, st, ra, ok, we;
    logic [2:0] f3;
    int lat, i, hold;
    for (int t = 0; t < 200; t++) begin
      i    = int'($urandom_range(0, NI - 1));
      we   = 1'($urandom);
      f3   = 3'($urandom_range(0, 7));
      wd   = {$urandom, $urandom};
      hold = int'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       ad = 64'h400 + 64'($urandom_range(0, 255));
        1:       ad = {1'b1, 55'd0, 8'($urandom)};
        default: ad = 64'($urandom_range(0, 127));
      endcase
      model(i, we, ad, wd, f3, exp_rd, exp_e);
      do_txn(i, we, ad, wd, f3, hold, rd, e, lat, st, ra, ok);
      checks++;
      if (!ok || lat != lat_of(i) || rd !== exp_rd || e !== exp_e || !st || !ra) begin
        errors++;
        $display("[TB] FAIL random[%0d] i%0d we=%b f3=%0d a=%h: got rd=%h err=%b lat=%0d st=%b rdy=%b want rd=%h err=%b lat=%0d",
                 t, i, we, f3, ad, rd, e, lat, st, ra, exp_rd, exp_e, lat_of(i));
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; req_funct3[i] = '0; rsp_ready[i] = 1'b0;
    end
    test_reset();
    test_prefill();
    test_lanes();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
